huffman_stream_checker: RTL and testbench
=========================================

Name: huffman_stream_checker

Overview:
- Synthesizable, parametrised checker that compares the Huffman Top response stream (resp_valid/resp_bits) against an expected-data memory loaded beforehand.
- Reports per-run pass/fail, mismatch count, first mismatch, early termination, extra outputs and timeout.
- Replaces the behavioural checking loops in the encode/decode bench, so the same check can run in simulation and on FPGA.
- Sits beside Top and watches io_resp_valid, io_resp_bits and io_req_ready; it drives nothing into Top.

Parameters:
- DATA_W, 8: width of one response symbol and of each expected-memory word.
- DEPTH, 1024: number of expected-memory entries.
- ADDR_W, $clog2(DEPTH): index/address width.
- CNT_W, 16: width of the error and extra-output counters. Both saturate.
- TIMEOUT, 10000: cycle limit per run, counted from start acceptance.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write expected-memory word. Honoured only when not busy.
- load_addr  in  ADDR_W  expected-memory write address.
- load_data  in  DATA_W  expected-memory write data.
- start  in  1  begin a run. Accepted in IDLE or DONE only.
- expected_len  in  ADDR_W+1  number of responses expected. Sampled when start is accepted.
- resp_valid  in  1  DUT response strobe.
- resp_bits  in  DATA_W  DUT response data.
- dut_idle  in  1  DUT io_req_ready; high means the DUT considers the job finished.
- busy  out  1  high in PRIME/RUN/DRAIN.
- done  out  1  high in DONE; stays high until the next accepted start.
- pass  out  1  valid while done. Equals no mismatches, no early_term, no extra_out and no timeout.
- err_count  out  CNT_W  number of mismatched symbols (saturating).
- extra_count  out  CNT_W  responses seen after expected_len (saturating).
- first_err_idx  out  ADDR_W  index of the first mismatch.
- first_err_exp  out  DATA_W  expected value at the first mismatch.
- first_err_got  out  DATA_W  received value at the first mismatch.
- early_term  out  1  sticky flag.
- timeout  out  1  sticky flag.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; idx=0; cycle counter=0. Memory contents are not reset.
- Memory:
  - Synchronous write; synchronous read with 1-cycle latency.
  - Read address = idx_next (combinational). The registered read data therefore always equals mem[idx] one cycle after idx updates.
  - load_en while busy is ignored (no write).
- States: IDLE, PRIME, RUN, DRAIN, DONE.
- Start (in IDLE or DONE):
  - Latch len; clear counters, flags and first_err_* registers; idx=0; cycle counter=0.
  - Go to PRIME. start in any other state is ignored.
- PRIME (1 cycle, memory fetch of index 0):
  - Go to RUN if len>0, else DRAIN.
  - resp_valid in PRIME is compared exactly as in RUN, using bypass of the fetched word.
- RUN, on each cycle with resp_valid:
  - If dut_idle is also high: set early_term, go to DONE, no compare.
  - Otherwise compare resp_bits with mem[idx]. On mismatch, err_count += 1 (saturating); if this is the first mismatch, capture idx, expected and got.
  - idx += 1. When idx+1 == len, go to DRAIN.
  - Cycles without resp_valid: hold.
- DRAIN:
  - resp_valid sets extra_out and increments extra_count (saturating). Stay in DRAIN.
  - dut_idle high (and resp_valid low) goes to DONE.
  - resp_valid together with dut_idle: count the extra response, then go to DONE.
- Timeout:
  - The cycle counter increments in PRIME/RUN/DRAIN.
  - When it reaches TIMEOUT: set timeout, go to DONE. This takes priority over all other transitions that cycle.
- DONE: done=1; pass computed combinationally from the flags and err_count==0.
- Reset mid-run: immediate return to IDLE, all outputs 0.

Decomposition:
- Shared package huffman_chk_pkg holds:
  - state enum {IDLE, PRIME, RUN, DRAIN, DONE};
  - default DATA_W/DEPTH/TIMEOUT constants shared with the bench.
- One sub-module: chk_mem, a DEPTH x DATA_W RAM with 1 write port and 1 synchronous read port, 1-cycle read latency.

Test Plan:
- Clean run: load mem[0..522] with the reference bytes, expected_len=523, replay identical bytes with random valid gaps, then dut_idle → done=1, pass=1, err_count=0, extra_count=0.
- Single mismatch: as above but byte 17 is corrupted to 0xAA → pass=0, err_count=1, first_err_idx=17, first_err_exp=mem[17], first_err_got=0xAA.
- Early termination: expected_len=1000, resp_valid with dut_idle=1 at index 400 → early_term=1, done=1, pass=0, err_count=0.
- Extra outputs: expected_len=4, send 6 valid responses, then dut_idle → extra_count=2, pass=0.
- Timeout: expected_len=10, send 3 responses, then silence → timeout=1 exactly TIMEOUT cycles after start acceptance, done=1, pass=0.
- Zero length / restart / reset:
  - start with expected_len=0, then dut_idle → pass=1.
  - Restart from DONE clears every flag and counter.
  - load_en asserted during RUN leaves the memory unchanged.
  - Asserting reset in RUN returns every output to 0 asynchronously.

Source files
------------

// File: rtl/huffman_chk_pkg.sv
// Shared definitions for the Huffman response-stream checker: FSM state
// encoding and the default geometry used by both the RTL and its bench.
package huffman_chk_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 10000;

  // Checker run states. The encoding is exported on state_dbg, so keep it stable.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } chk_state_t;

endpackage

// File: rtl/chk_mem.sv
// Expected-data RAM for the stream checker: one write port and one read port,
// both synchronous. Read data appears one cycle after the address is presented.
module chk_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port. A same-cycle write to the same address returns the old word.
  always_ff @(posedge clock) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/huffman_stream_checker.sv
// Stream checker that sits beside the Huffman Top and compares its response
// stream against a preloaded expected-data memory, reporting pass/fail,
// mismatch statistics, early termination, extra outputs and timeout.
//
// Handshake: resp_valid is a one-way strobe with no ready. Every cycle in
// which resp_valid is high delivers exactly one symbol on resp_bits, and the
// checker never stalls the source. dut_idle high means the source considers
// its job finished; a symbol that arrives together with dut_idle during the
// compare phase is treated as early termination and is not compared.
module huffman_stream_checker
  import huffman_chk_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   expected_len,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_bits,
  input  logic              dut_idle,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  extra_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              early_term,
  output logic              timeout,
  output logic [2:0]        state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  chk_state_t        state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [ADDR_W:0]   idx_inc;
  logic [TO_W-1:0]   cyc;
  logic [TO_W-1:0]   cyc_inc;
  logic              extra_out;
  logic              have_err;
  logic [DATA_W-1:0] rd_data;

  logic              start_ok;
  logic              in_cmp;
  logic              timeout_hit;
  logic              cmp_fire;
  logic              early_fire;
  logic              mismatch;

  // Loads are only honoured while no run is in flight.
  chk_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (load_en && !busy),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (idx_next),
    .rdata (rd_data)
  );

  assign state_dbg = state;
  assign idx_inc   = {1'b0, idx} + (ADDR_W + 1)'(1);
  assign cyc_inc   = cyc + TO_W'(1);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  // PRIME already holds mem[0] on the read port, so it compares like RUN
  // whenever the run has at least one expected symbol.
  assign in_cmp      = (state == RUN) || ((state == PRIME) && (len != '0));
  assign timeout_hit = busy && (cyc_inc == TO_W'(TIMEOUT));
  assign cmp_fire    = in_cmp && resp_valid && !dut_idle && !timeout_hit;
  assign early_fire  = in_cmp && resp_valid && dut_idle && !timeout_hit;
  assign mismatch    = (resp_bits != rd_data);

  assign pass = done && !early_term && !extra_out && !timeout && (err_count == '0);

  // Next read index: reset to 0 on start, advance on every compared symbol,
  // so the registered read data always equals mem[idx].
  always_comb begin
    idx_next = idx;
    if (start_ok) begin
      idx_next = '0;
    end else if (cmp_fire) begin
      idx_next = idx_inc[ADDR_W-1:0];
    end
  end

  // Run FSM with its counters, sticky flags and first-mismatch capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      len           <= '0;
      idx           <= '0;
      cyc           <= '0;
      err_count     <= '0;
      extra_count   <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      early_term    <= 1'b0;
      timeout       <= 1'b0;
      extra_out     <= 1'b0;
      have_err      <= 1'b0;
    end else begin
      idx <= idx_next;
      if ((state == IDLE) || (state == DONE)) begin
        if (start) begin
          state         <= PRIME;
          busy          <= 1'b1;
          done          <= 1'b0;
          len           <= expected_len;
          cyc           <= '0;
          err_count     <= '0;
          extra_count   <= '0;
          first_err_idx <= '0;
          first_err_exp <= '0;
          first_err_got <= '0;
          early_term    <= 1'b0;
          timeout       <= 1'b0;
          extra_out     <= 1'b0;
          have_err      <= 1'b0;
        end
      end else begin
        cyc <= cyc_inc;
        if (timeout_hit) begin
          // The cycle limit overrides every other event this cycle.
          timeout <= 1'b1;
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end else if (state == DRAIN) begin
          if (resp_valid) begin
            extra_out <= 1'b1;
            if (extra_count != {CNT_W{1'b1}}) begin
              extra_count <= extra_count + CNT_W'(1);
            end
          end
          if (dut_idle) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else if (!in_cmp) begin
          // Zero-length run: nothing to compare, anything arriving is extra.
          if (resp_valid) begin
            extra_out <= 1'b1;
            if (extra_count != {CNT_W{1'b1}}) begin
              extra_count <= extra_count + CNT_W'(1);
            end
          end
          state <= DRAIN;
        end else if (early_fire) begin
          early_term <= 1'b1;
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
        end else if (cmp_fire) begin
          if (mismatch) begin
            if (err_count != {CNT_W{1'b1}}) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (!have_err) begin
              have_err      <= 1'b1;
              first_err_idx <= idx;
              first_err_exp <= rd_data;
              first_err_got <= resp_bits;
            end
          end
          if (idx_inc == len) begin
            state <= DRAIN;
          end else begin
            state <= RUN;
          end
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_stream_checker.sv
// Self-checking bench for huffman_stream_checker: directed scenarios plus
// randomized streams, each checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_huffman_stream_checker;
  import huffman_chk_pkg::*;

  localparam int DATA_W  = DEF_DATA_W;
  localparam int DEPTH   = DEF_DEPTH;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = DEF_CNT_W;
  localparam int TIMEOUT = DEF_TIMEOUT;

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [ADDR_W:0]   expected_len;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_bits;
  logic              dut_idle;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  extra_count;
  logic [ADDR_W-1:0] first_err_idx;
  logic [DATA_W-1:0] first_err_exp;
  logic [DATA_W-1:0] first_err_got;
  logic              early_term;
  logic              timeout;
  logic [2:0]        state_dbg;

  always #5 clock = ~clock;

  huffman_stream_checker #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .expected_len  (expected_len),
    .resp_valid    (resp_valid),
    .resp_bits     (resp_bits),
    .dut_idle      (dut_idle),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .extra_count   (extra_count),
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got),
    .early_term    (early_term),
    .timeout       (timeout),
    .state_dbg     (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                m_err, m_extra, m_fidx, m_fexp, m_fgot;
  logic              m_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int a, input logic [DATA_W-1:0] d);
    load_en   = 1'b1;
    load_addr = a[ADDR_W-1:0];
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic start_run(input int len);
    expected_len = len[ADDR_W:0];
    start        = 1'b1;
    tick();
    start        = 1'b0;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[i]);
  endtask

  task automatic send_resp(input logic [DATA_W-1:0] b, input int max_gap);
    int gap;
    gap = $urandom_range(0, max_gap);
    resp_valid = 1'b0;
    repeat (gap) tick();
    resp_valid = 1'b1;
    resp_bits  = b;
    tick();
    resp_valid = 1'b0;
    got_q.push_back(b);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check("wait_done", 32'(done), 32'd1);
  endtask

  task automatic finish_idle();
    dut_idle = 1'b1;
    wait_done(50);
    dut_idle = 1'b0;
  endtask

  // Reference: symbol i of the stream is compared with expected word i while
  // i < len; every later symbol is an extra output.
  task automatic model_run();
    m_err = 0; m_extra = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i < exp_q.size()) begin
        if (got_q[i] != exp_q[i]) begin
          if (m_err == 0) begin
            m_fidx = i;
            m_fexp = int'(exp_q[i]);
            m_fgot = int'(got_q[i]);
          end
          m_err++;
        end
      end else begin
        m_extra++;
      end
    end
    m_pass = (m_err == 0) && (m_extra == 0);
  endtask

  task automatic check_model(input string tag);
    model_run();
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'(m_pass));
    check({tag, "_err"},   32'(err_count), 32'(m_err));
    check({tag, "_extra"}, 32'(extra_count), 32'(m_extra));
    check({tag, "_fidx"},  32'(first_err_idx), 32'(m_fidx));
    check({tag, "_fexp"},  32'(first_err_exp), 32'(m_fexp));
    check({tag, "_fgot"},  32'(first_err_got), 32'(m_fgot));
    check({tag, "_early"}, 32'(early_term), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_err"},   32'(err_count), 32'd0);
    check({tag, "_extra"}, 32'(extra_count), 32'd0);
    check({tag, "_fidx"},  32'(first_err_idx), 32'd0);
    check({tag, "_fexp"},  32'(first_err_exp), 32'd0);
    check({tag, "_fgot"},  32'(first_err_got), 32'd0);
    check({tag, "_early"}, 32'(early_term), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] d;
    int                len;
    int                n_extra;

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; expected_len = '0; resp_valid = 1'b0; resp_bits = '0;
    dut_idle = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset");

    // Fill the expected memory with random bytes.
    for (int i = 0; i < DEPTH; i++) begin
      d = DATA_W'($urandom);
      if (i == 17 && d == 8'hAA) d = 8'h55;
      ref_mem[i] = d;
      load_word(i, d);
    end

    // Clean run; a load to a future address mid-run must be ignored.
    start_run(523);
    for (int i = 0; i < 523; i++) begin
      if (i == 100) begin
        load_en   = 1'b1;
        load_addr = 10'd300;
        load_data = ~ref_mem[300];
      end
      send_resp(exp_q[i], 2);
      load_en = 1'b0;
    end
    finish_idle();
    check_model("clean");

    // Single corrupted byte at index 17.
    start_run(523);
    for (int i = 0; i < 523; i++) send_resp((i == 17) ? 8'hAA : exp_q[i], 2);
    finish_idle();
    check_model("mism");
    check("mism_fidx17", 32'(first_err_idx), 32'd17);
    check("mism_fgotAA", 32'(first_err_got), 32'hAA);

    // Restart from DONE clears everything; zero-length run then passes.
    start_run(0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_err",  32'(err_count), 32'd0);
    check("restart_fidx", 32'(first_err_idx), 32'd0);
    check("restart_fgot", 32'(first_err_got), 32'd0);
    finish_idle();
    check_model("zero");
    check("zero_pass", 32'(pass), 32'd1);

    // Extra outputs: 4 expected, 6 delivered.
    start_run(4);
    for (int i = 0; i < 6; i++) send_resp(ref_mem[i], 1);
    finish_idle();
    check_model("extra");
    check("extra_cnt2", 32'(extra_count), 32'd2);

    // Early termination at index 400 of 1000.
    start_run(1000);
    for (int i = 0; i < 400; i++) send_resp(exp_q[i], 1);
    resp_valid = 1'b1;
    resp_bits  = ref_mem[400];
    dut_idle   = 1'b1;
    tick();
    resp_valid = 1'b0;
    dut_idle   = 1'b0;
    check("early_done", 32'(done), 32'd1);
    check("early_flag", 32'(early_term), 32'd1);
    check("early_pass", 32'(pass), 32'd0);
    check("early_err",  32'(err_count), 32'd0);

    // Timeout exactly TIMEOUT cycles after start acceptance.
    start_run(10);
    for (int i = 0; i < 3; i++) send_resp(exp_q[i], 0);
    repeat (TIMEOUT - 4) tick();
    check("tmo_not_yet", 32'(done), 32'd0);
    tick();
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_pass", 32'(pass), 32'd0);

    // Restart after timeout clears the sticky flags.
    start_run(0);
    check("restart2_tmo",   32'(timeout), 32'd0);
    check("restart2_early", 32'(early_term), 32'd0);
    finish_idle();
    check_model("zero2");

    // Randomized streams with sparse corruption and a few extras.
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(20, 120);
      start_run(len);
      for (int i = 0; i < len; i++) begin
        d = exp_q[i];
        if ($urandom_range(0, 9) == 0) d = d ^ DATA_W'($urandom_range(1, 255));
        send_resp(d, 2);
      end
      n_extra = $urandom_range(0, 3);
      for (int i = 0; i < n_extra; i++) send_resp(DATA_W'($urandom), 1);
      finish_idle();
      check_model($sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run.
    start_run(50);
    for (int i = 0; i < 10; i++) send_resp((i == 3) ? ~exp_q[i] : exp_q[i], 0);
    check("pre_reset_err", 32'(err_count), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b0;
    tick();

    // Memory survives reset.
    start_run(20);
    for (int i = 0; i < 20; i++) send_resp(exp_q[i], 1);
    finish_idle();
    check_model("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
